// File: rtl/multi_control_unit_if.sv
// ---------------------------------------------------------------------------
// multi_control_unit_if : opcode/flag inputs and datapath control outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multi_control_unit_if;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       ExtSel;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       DBDataSrc;
  logic       mRD;
  logic       mWR;
  logic [1:0] PCSrc;

  modport master (
    output op, zero, sign,
    input  state, PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegWre,
           RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc
  );

  modport slave (
    input  op, zero, sign,
    output state, PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegWre,
           RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc
  );
endinterface

`default_nettype wire

// File: rtl/multi_control_unit.sv
// ---------------------------------------------------------------------------
// multi_control_unit : IF/ID/EXE/MEM/WB sequencer for the multi-cycle CPU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_control_unit (
  input  logic                 CLK,
  input  logic                 Reset,
  multi_control_unit_if.slave  bus
);

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_AL  = 3'b111;
  localparam logic [2:0] S_WB_LD  = 3'b100;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic is_add, is_sub, is_addiu, is_and, is_andi, is_ori, is_sll, is_slt, is_slti;
  logic is_sw, is_lw, is_beq, is_bne, is_bltz, is_j, is_jr, is_jal, is_halt;
  logic is_alu, is_itype, is_ls, is_br;

  assign is_add   = (bus.op == OP_ADD);
  assign is_sub   = (bus.op == OP_SUB);
  assign is_addiu = (bus.op == OP_ADDIU);
  assign is_and   = (bus.op == OP_AND);
  assign is_andi  = (bus.op == OP_ANDI);
  assign is_ori   = (bus.op == OP_ORI);
  assign is_sll   = (bus.op == OP_SLL);
  assign is_slt   = (bus.op == OP_SLT);
  assign is_slti  = (bus.op == OP_SLTI);
  assign is_sw    = (bus.op == OP_SW);
  assign is_lw    = (bus.op == OP_LW);
  assign is_beq   = (bus.op == OP_BEQ);
  assign is_bne   = (bus.op == OP_BNE);
  assign is_bltz  = (bus.op == OP_BLTZ);
  assign is_j     = (bus.op == OP_J);
  assign is_jr    = (bus.op == OP_JR);
  assign is_jal   = (bus.op == OP_JAL);
  assign is_halt  = (bus.op == OP_HALT);

  assign is_itype = is_addiu | is_andi | is_ori | is_slti;
  assign is_alu   = is_add | is_sub | is_and | is_sll | is_slt | is_itype;
  assign is_ls    = is_lw | is_sw;
  assign is_br    = is_beq | is_bne | is_bltz;

  // Reset overrides any state, including mid-instruction.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID: begin
        if (is_alu)       state_d = S_EXE_AL;
        else if (is_ls)   state_d = S_EXE_LS;
        else if (is_br)   state_d = S_EXE_BR;
        else if (is_halt) state_d = S_ID;
        else              state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  logic [2:0] alu_op_sel;
  always_comb begin
    alu_op_sel = ALU_ADD;
    if (is_sub)                 alu_op_sel = ALU_SUB;
    else if (is_sll)            alu_op_sel = ALU_SLL;
    else if (is_ori)            alu_op_sel = ALU_OR;
    else if (is_and | is_andi)  alu_op_sel = ALU_AND;
    else if (is_slt | is_slti)  alu_op_sel = ALU_SLT;
  end

  logic       pc_wre_d, ir_wre_d, reg_wre_d, m_wr_d, m_rd_d;
  logic       alu_src_a_d, alu_src_b_d, wr_reg_d_src_d, db_data_src_d;
  logic [2:0] alu_op_d;
  logic [1:0] reg_dst_d, pc_src_d;

  always_comb begin
    pc_wre_d       = 1'b0;
    ir_wre_d       = 1'b0;
    reg_wre_d      = 1'b0;
    m_wr_d         = 1'b0;
    m_rd_d         = 1'b0;
    alu_src_a_d    = 1'b0;
    alu_src_b_d    = 1'b0;
    wr_reg_d_src_d = 1'b0;
    db_data_src_d  = 1'b0;
    alu_op_d       = ALU_ADD;
    reg_dst_d      = 2'b00;
    pc_src_d       = 2'b00;
    case (state_q)
      S_IF: ir_wre_d = 1'b1;
      S_ID: begin
        // Jumps and NOPs retire here; halt and multi-cycle ops stay quiet.
        if (is_j | is_jal) begin
          pc_wre_d = 1'b1;
          pc_src_d = 2'b11;
          reg_wre_d = is_jal;
        end else if (is_jr) begin
          pc_wre_d = 1'b1;
          pc_src_d = 2'b10;
        end else if (!(is_alu | is_ls | is_br | is_halt)) begin
          pc_wre_d = 1'b1;
        end
      end
      S_EXE_AL, S_WB_AL: begin
        alu_src_a_d = is_sll;
        alu_src_b_d = is_itype;
        alu_op_d    = alu_op_sel;
        if (state_q == S_WB_AL) begin
          reg_wre_d      = 1'b1;
          wr_reg_d_src_d = 1'b1;
          pc_wre_d       = 1'b1;
          reg_dst_d      = is_itype ? 2'b01 : 2'b10;
        end
      end
      S_EXE_BR: begin
        alu_op_d = ALU_SUB;
        pc_wre_d = 1'b1;
        if ((is_beq & bus.zero) | (is_bne & ~bus.zero) | (is_bltz & bus.sign))
          pc_src_d = 2'b01;
      end
      S_EXE_LS, S_MEM: begin
        alu_src_b_d = 1'b1;
        if (state_q == S_MEM) begin
          m_rd_d   = is_lw;
          m_wr_d   = is_sw;
          pc_wre_d = is_sw;
        end
      end
      S_WB_LD: begin
        reg_wre_d      = 1'b1;
        reg_dst_d      = 2'b01;
        wr_reg_d_src_d = 1'b1;
        db_data_src_d  = 1'b1;
        m_rd_d         = 1'b1;
        pc_wre_d       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.PCWre     = pc_wre_d  & Reset;
  assign bus.IRWre     = ir_wre_d  & Reset;
  assign bus.RegWre    = reg_wre_d & Reset;
  assign bus.mWR       = m_wr_d    & Reset;
  assign bus.mRD       = m_rd_d;
  assign bus.ExtSel    = is_addiu | is_slti | is_ls | is_br;
  assign bus.ALUSrcA   = alu_src_a_d;
  assign bus.ALUSrcB   = alu_src_b_d;
  assign bus.ALUOp     = alu_op_d;
  assign bus.RegDst    = reg_dst_d;
  assign bus.WrRegDSrc = wr_reg_d_src_d;
  assign bus.DBDataSrc = db_data_src_d;
  assign bus.PCSrc     = pc_src_d;

endmodule

`default_nettype wire

// File: doc/multi_control_unit.md
Name: multi_control_unit

Overview:
- Multi-cycle control unit (state machine) for the multi-cycle CPU. It sits directly upstream of the immediate extender and drives its ExtSel input.
- Each cycle it decodes the latched opcode together with the ALU flags. It generates the PC, IR, register-file, ALU, memory and extender control signals for the IF/ID/EXE/MEM/WB sequence.

Parameters:
- S_IF, 3'b000, instruction fetch state code
- S_ID, 3'b001, decode / register read state code
- S_EXE_AL, 3'b110, ALU execute state code
- S_EXE_BR, 3'b101, branch compare state code
- S_EXE_LS, 3'b010, load/store address-calculation state code
- S_MEM, 3'b011, memory access state code
- S_WB_AL, 3'b111, ALU writeback state code
- S_WB_LD, 3'b100, load writeback state code

Ports:
- CLK  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- op  in  6  opcode from the instruction register
- zero  in  1  ALU result == 0
- sign  in  1  ALU result bit 31
- state  out  3  current state code
- PCWre  out  1  PC write enable
- IRWre  out  1  instruction register write enable
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend the 16-bit immediate
- ALUSrcA  out  1  0 = rs, 1 = sa (zero-extended)
- ALUSrcB  out  1  0 = rt, 1 = extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 signed slt
- RegWre  out  1  register-file write enable
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4, 1 = data bus
- DBDataSrc  out  1  0 = ALU result, 1 = data-memory output
- mRD  out  1  data-memory read
- mWR  out  1  data-memory write
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010
  - sll 011000, slt 100110, slti 100111
  - sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- Any other opcode is a NOP.
- State register:
  - Clocked; Reset==0 at a rising edge loads S_IF, which overrides any state, including mid-instruction.
  - While Reset==0, PCWre, IRWre, RegWre and mWR are forced to 0.
  - All other outputs are combinational from (state, op, zero, sign).
- Transitions:
  - IF -> ID, always.
  - ID -> EXE_AL for add, sub, addiu, and, andi, ori, sll, slt, slti.
  - ID -> EXE_LS for lw, sw.
  - ID -> EXE_BR for beq, bne, bltz.
  - ID -> IF for j, jr, jal and NOP.
  - ID -> ID for halt, which stays there until reset.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD for lw; MEM -> IF for sw.
  - WB_LD -> IF.
- Per-state outputs (every unlisted output = 0):
  - IF: IRWre=1.
  - ID (j): PCWre=1, PCSrc=11.
  - ID (jr): PCWre=1, PCSrc=10.
  - ID (jal): PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
  - ID (NOP): PCWre=1, PCSrc=00.
  - ID (halt): all 0.
  - EXE_AL: ALUSrcA=1 only for sll. ALUSrcB=1 for addiu, andi, ori, slti. ALUOp per opcode: addiu -> add, andi -> and, ori -> or, slti -> slt.
  - EXE_BR: ALUOp=001, PCWre=1. PCSrc=01 iff (beq&zero) | (bne&~zero) | (bltz&sign), else 00.
  - EXE_LS: ALUSrcB=1, ALUOp=000.
  - MEM: mRD=1 for lw; mWR=1, PCWre=1, PCSrc=00 for sw. ALUSrcB and ALUOp are held as in EXE_LS so the address stays stable.
  - WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. RegDst=01 for I-type, 10 for R-type. EXE_AL ALU controls are held.
  - WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, mRD=1, PCWre=1, PCSrc=00.
- ExtSel:
  - 1 in every state for addiu, slti, lw, sw, beq, bne, bltz.
  - 0 for andi, ori and all other opcodes.
- PCWre is high in exactly one cycle per instruction: the final state. Halt and reset are the exceptions.
- Instruction latency:
  - j/jr/jal/NOP: 2 cycles.
  - branch: 3 cycles.
  - ALU and sw: 4 cycles.
  - lw: 5 cycles.

Test Plan:
- Hold Reset=0 for 2 edges with op=add -> state=000, PCWre=IRWre=RegWre=mWR=0. Release Reset -> IRWre=1 in cycle 1 and state=001 in cycle 2.
- addiu (op=000010) -> states 000, 001, 110, 111. ExtSel=1 and ALUSrcB=1 throughout EXE/WB. RegDst=01 and RegWre=1 only in 111. PCWre=1 only in 111.
- beq with zero=1 -> state 101 with PCSrc=01, PCWre=1. Repeat with zero=0 -> PCSrc=00. bltz with sign=1 -> PCSrc=01.
- lw (110001) -> states 000, 001, 010, 011, 100. mRD=1 in 011 and 100. DBDataSrc=1 and RegWre=1 in 100. sw -> mWR=1 and PCWre=1 in 011, then 000.
- jal (111010) -> in 001: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1; next state 000. ori -> ExtSel=0.
- halt (111111) -> state stays 001 for 10 cycles with PCWre=0. Reset=0 pulsed in state 011 of a lw -> next state 000, with no RegWre during the reset cycle.
